// File: rtl/rx_pkg.sv
// Shared definitions for the TCP Rx byte-to-word packer: word geometry,
// lane ordering and the pack-control state encoding.
package rx_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int PHASE_W        = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // The first byte received lands in the least significant lane.
  localparam bit LSB_FIRST = 1'b1;

  // Pack control: IDLE holds no bytes, FILL holds 1..3 bytes,
  // DROP is the single cycle that follows discarding a partial word.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } pack_state_e;

  // Lane of the pack register that receives the byte arriving at 'phase'.
  function automatic logic [PHASE_W-1:0] lane_of(input logic [PHASE_W-1:0] phase);
    if (LSB_FIRST) return phase;
    else           return PHASE_W'(BYTES_PER_WORD - 1) - phase;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Generic synchronous first-word-fall-through FIFO with an occupancy
// count. The head entry is presented on rd_data_o whenever the FIFO is
// not empty; rd_data_o reads as zero while empty.
module rx_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees the head slot in the same cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full | rd_ok);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale contents are never seen.
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/tcp_rx_8_to_32.sv
// Drains the TCP Rx byte stream through the EMPTY/RE/RV/RD handshake,
// packs every 4 bytes into a 32-bit word (first byte least significant)
// and buffers the words in an FWFT FIFO for the USR_CLK consumer.
// A partial word is discarded when the connection drops, and counted.
module tcp_rx_8_to_32
  import rx_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 USR_ACTIVE,
  input  logic                 USR_RX_EMPTY,
  output logic                 USR_RX_RE,
  input  logic                 USR_RX_RV,
  input  logic [7:0]           USR_RX_RD,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [WORD_W-1:0]    FIFO_DATA,
  output logic [PHASE_W-1:0]   BYTE_PHASE,
  output logic [CNT_WIDTH-1:0] DROP_COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;

  pack_state_e          state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [WORD_W-1:0]    pack_q, pack_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 post_rst_q;
  logic [WORD_W-1:0]    merged;
  logic                 word_wr;
  logic                 rx_rv;
  logic [CW-1:0]        word_count;

  // A byte requested before reset may still arrive in the first cycle
  // after it; that byte belongs to the discarded context and is dropped.
  assign rx_rv = USR_RX_RV & ~post_rst_q;

  // Keep one FIFO slot in reserve: with at most one byte in flight, at
  // most one more word can complete after RE falls, so no byte is lost.
  assign USR_RX_RE = RSTn & ~post_rst_q & USR_ACTIVE & ~USR_RX_EMPTY
                   & (word_count < CW'(DEPTH - 1));

  assign BYTE_PHASE = phase_q;
  assign DROP_COUNT = drop_q;

  // Pack control next-state: byte capture, word completion and drop handling.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the block
    // stays purely combinational and no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    pack_d  = pack_q;
    drop_d  = drop_q;
    word_wr = 1'b0;
    merged  = pack_q;
    merged[8*lane_of(phase_q) +: 8] = USR_RX_RD;

    // The cycle after a discard bumps the saturating counter.
    if (state_q == ST_DROP) begin
      state_d = ST_IDLE;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end

    if (rx_rv) begin
      // Arriving bytes are always accepted, even with the connection down.
      if (phase_q == PHASE_W'(BYTES_PER_WORD - 1)) begin
        word_wr = 1'b1;
        phase_d = '0;
        pack_d  = '0;
        state_d = ST_IDLE;
      end else begin
        phase_d = phase_q + 1'b1;
        pack_d  = merged;
        state_d = ST_FILL;
      end
    end else if (!USR_ACTIVE && state_q == ST_FILL) begin
      phase_d = '0;
      pack_d  = '0;
      state_d = ST_DROP;
    end
  end

  // Pack control state register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      pack_q     <= '0;
      drop_q     <= '0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pack_q     <= pack_d;
      drop_q     <= drop_d;
      post_rst_q <= 1'b0;
    end
  end

  rx_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_word_fifo (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .wr_en_i   (word_wr),
    .wr_data_i (merged),
    .rd_en_i   (FIFO_READ),
    .rd_data_o (FIFO_DATA),
    .empty_o   (FIFO_EMPTY),
    .count_o   (word_count)
  );

endmodule

// File: tb/tb_tcp_rx_8_to_32.sv
// Directed bench for tcp_rx_8_to_32: a byte-source model answers RE with
// RV one cycle later, a packing model pushes expected words into a
// scoreboard, and every FIFO pop is compared against the scoreboard head.
module tb_tcp_rx_8_to_32;

  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 8;

  logic                 CLK = 1'b0;
  logic                 RSTn;
  logic                 USR_ACTIVE;
  logic                 USR_RX_EMPTY;
  logic                 USR_RX_RE;
  logic                 USR_RX_RV;
  logic [7:0]           USR_RX_RD;
  logic                 FIFO_READ;
  logic                 FIFO_EMPTY;
  logic [31:0]          FIFO_DATA;
  logic [1:0]           BYTE_PHASE;
  logic [CNT_WIDTH-1:0] DROP_COUNT;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  src_q[$];
  logic [31:0] exp_q[$];
  logic        re_s = 1'b0;
  bit          auto_src = 1'b0;
  int          mphase = 0;
  logic [31:0] mpack = '0;
  bit          mmask = 1'b0;
  int          words_popped = 0;

  always #4 CLK = ~CLK;

  tcp_rx_8_to_32 #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .USR_ACTIVE   (USR_ACTIVE),
    .USR_RX_EMPTY (USR_RX_EMPTY),
    .USR_RX_RE    (USR_RX_RE),
    .USR_RX_RV    (USR_RX_RV),
    .USR_RX_RD    (USR_RX_RD),
    .FIFO_READ    (FIFO_READ),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FIFO_DATA    (FIFO_DATA),
    .BYTE_PHASE   (BYTE_PHASE),
    .DROP_COUNT   (DROP_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag, input int max);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout after %0d cycles, expected completion", tag, max);
  endtask

  // One clock cycle. Entered and left at the falling edge: the current
  // cycle's inputs are final, so the models consume them, then the source
  // model drives its response just after the rising edge.
  task automatic cycle();
    logic [31:0] e;
    re_s = USR_RX_RE;
    if (!RSTn) begin
      mphase = 0;
      mpack  = '0;
      exp_q.delete();
      mmask  = 1'b1;
    end else begin
      if (mmask) begin
        mmask = 1'b0;
      end else if (USR_RX_RV) begin
        mpack[8*mphase +: 8] = USR_RX_RD;
        if (mphase == 3) begin
          exp_q.push_back(mpack);
          mphase = 0;
          mpack  = '0;
        end else begin
          mphase++;
        end
      end else if (!USR_ACTIVE) begin
        mphase = 0;
        mpack  = '0;
      end
      if (FIFO_READ && !FIFO_EMPTY) begin
        words_popped++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pop_extra: observed word 0x%0h, expected no word", FIFO_DATA);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", FIFO_DATA, e);
        end
      end
    end
    @(posedge CLK);
    #1;
    if (auto_src) begin
      USR_RX_RV = re_s && (src_q.size() != 0);
      if (USR_RX_RV) USR_RX_RD = src_q.pop_front();
      USR_RX_EMPTY = (src_q.size() == 0);
    end
    @(negedge CLK);
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    if (auto_src) USR_RX_EMPTY = 1'b0;
  endtask

  task automatic do_reset();
    auto_src     = 1'b0;
    src_q.delete();
    USR_RX_RV    = 1'b0;
    USR_RX_RD    = '0;
    FIFO_READ    = 1'b0;
    USR_ACTIVE   = 1'b1;
    USR_RX_EMPTY = 1'b0;
    RSTn         = 1'b0;
    cycle();
    check("rst_re", USR_RX_RE, 0);
    check("rst_fifo_empty", FIFO_EMPTY, 1);
    check("rst_fifo_data", FIFO_DATA, 0);
    check("rst_phase", BYTE_PHASE, 0);
    check("rst_drop", DROP_COUNT, 0);
    cycle();
    USR_RX_EMPTY = 1'b1;
    RSTn         = 1'b1;
    cycle();
    auto_src = 1'b1;
  endtask

  // Run until the DUT has stopped requesting and no byte is in flight.
  task automatic wait_stall(input string tag, input int max);
    int n = 0;
    #1;
    while (!(USR_RX_RE === 1'b0 && USR_RX_RV === 1'b0) && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) fail_timeout(tag, max);
  endtask

  // Pop continuously until the source, the DUT and the scoreboard are empty.
  task automatic drain(input string tag, input int max);
    int n = 0;
    #1;
    words_popped = 0;
    FIFO_READ = 1'b1;
    while (!(FIFO_EMPTY && exp_q.size() == 0 && src_q.size() == 0 &&
             !USR_RX_RV && !USR_RX_RE) && n < max) begin
      cycle();
      n++;
    end
    FIFO_READ = 1'b0;
    if (n >= max) fail_timeout(tag, max);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected summary");
    $fatal(1);
  end

  initial begin
    int n;
    RSTn = 1'b0; USR_ACTIVE = 1'b0; USR_RX_EMPTY = 1'b1;
    USR_RX_RV = 1'b0; USR_RX_RD = '0; FIFO_READ = 1'b0;
    @(negedge CLK);

    // 1: one word from four bytes, FIFO_EMPTY falls one cycle after the 4th RV.
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    n = 0;
    while (!(USR_RX_RV && USR_RX_RD == 8'h44) && n < 10) begin cycle(); n++; end
    if (n >= 10) fail_timeout("t1_fourth_rv", 10);
    check("t1_empty_at_4th_rv", FIFO_EMPTY, 1);
    check("t1_phase_at_4th_rv", BYTE_PHASE, 3);
    cycle();
    check("t1_empty_after", FIFO_EMPTY, 0);
    check("t1_data", FIFO_DATA, 32'h44332211);
    check("t1_phase_wrap", BYTE_PHASE, 0);
    drain("t1_drain", 20);
    check("t1_words", words_popped, 1);

    // 2: 80 bytes with no reads -> stall at 15 words with one byte held.
    do_reset();
    for (int i = 0; i < 80; i++) push_byte(8'(i + 1));
    wait_stall("t2_stall", 200);
    repeat (5) cycle();
    check("t2_re_stalled", USR_RX_RE, 0);
    check("t2_bytes_left", src_q.size(), 19);
    check("t2_phase", BYTE_PHASE, 1);
    check("t2_head", FIFO_DATA, 32'h04030201);
    drain("t2_drain", 300);
    check("t2_words", words_popped, 20);

    // 3: 6 bytes then disconnect -> one word kept, one drop, realigned restart.
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'(i + 1));
    wait_stall("t3_stall", 30);
    check("t3_phase_before", BYTE_PHASE, 2);
    USR_ACTIVE = 1'b0;
    repeat (3) cycle();
    check("t3_phase_cleared", BYTE_PHASE, 0);
    check("t3_drop", DROP_COUNT, 1);
    check("t3_word_kept", FIFO_DATA, 32'h04030201);
    USR_ACTIVE = 1'b1;
    push_byte(8'haa); push_byte(8'hbb); push_byte(8'hcc); push_byte(8'hdd);
    wait_stall("t3_restart", 30);
    FIFO_READ = 1'b1;
    cycle();
    FIFO_READ = 1'b0;
    check("t3_realigned", FIFO_DATA, 32'hddccbbaa);
    drain("t3_drain", 20);

    // 4: drop counter saturation.
    do_reset();
    auto_src = 1'b0;
    USR_ACTIVE = 1'b0;
    for (int i = 0; i < 200; i++) begin
      USR_RX_RV = 1'b1; USR_RX_RD = 8'(i); cycle();
      USR_RX_RV = 1'b0; cycle();
    end
    repeat (2) cycle();
    check("t4_drop_200", DROP_COUNT, 200);
    for (int i = 0; i < 100; i++) begin
      USR_RX_RV = 1'b1; USR_RX_RD = 8'(i); cycle();
      USR_RX_RV = 1'b0; cycle();
    end
    repeat (2) cycle();
    check("t4_drop_sat", DROP_COUNT, 255);
    check("t4_no_words", FIFO_EMPTY, 1);
    USR_ACTIVE = 1'b1;
    auto_src = 1'b1;

    // 5a: read and write together at count=1.
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    n = 0;
    while (!(USR_RX_RV && BYTE_PHASE == 2'd3 && !FIFO_EMPTY) && n < 20) begin cycle(); n++; end
    if (n >= 20) fail_timeout("t5_cnt1_align", 20);
    FIFO_READ = 1'b1;
    cycle();
    FIFO_READ = 1'b0;
    check("t5_cnt1_not_empty", FIFO_EMPTY, 0);
    check("t5_cnt1_new_head", FIFO_DATA, 32'h17161514);
    drain("t5_cnt1_drain", 20);
    check("t5_cnt1_words", words_popped, 1);

    // 5b: read and write together at count=DEPTH-1.
    do_reset();
    for (int i = 0; i < 62; i++) push_byte(8'(8'h40 + i));
    wait_stall("t5_full_stall", 200);
    check("t5_full_phase", BYTE_PHASE, 1);
    auto_src = 1'b0;
    USR_RX_RV = 1'b1; USR_RX_RD = 8'ha1; cycle();
    USR_RX_RD = 8'ha2; cycle();
    USR_RX_RD = 8'ha3; FIFO_READ = 1'b1; cycle();
    USR_RX_RV = 1'b0; FIFO_READ = 1'b0;
    #1;
    check("t5_full_re_held", USR_RX_RE, 0);
    check("t5_full_head", FIFO_DATA, 32'h47464544);
    cycle();
    check("t5_full_re_still", USR_RX_RE, 0);
    auto_src = 1'b1;
    drain("t5_full_drain", 300);
    check("t5_full_words", words_popped, 15);

    // 6: reset mid-word with buffered words; in-flight byte is ignored.
    do_reset();
    push_byte(8'h01); push_byte(8'h02);
    wait_stall("t6_pre", 20);
    USR_ACTIVE = 1'b0;
    repeat (3) cycle();
    USR_ACTIVE = 1'b1;
    for (int i = 0; i < 14; i++) push_byte(8'(8'h20 + i));
    wait_stall("t6_fill", 40);
    check("t6_phase_before", BYTE_PHASE, 2);
    check("t6_drop_before", DROP_COUNT, 1);
    check("t6_buffered", FIFO_EMPTY, 0);
    RSTn = 1'b0;
    cycle();
    RSTn = 1'b1;
    auto_src = 1'b0;
    USR_RX_RV = 1'b1; USR_RX_RD = 8'h99; USR_RX_EMPTY = 1'b0;
    #1;
    check("t6_empty", FIFO_EMPTY, 1);
    check("t6_phase", BYTE_PHASE, 0);
    check("t6_re", USR_RX_RE, 0);
    check("t6_drop", DROP_COUNT, 0);
    check("t6_data", FIFO_DATA, 0);
    cycle();
    USR_RX_RV = 1'b0; USR_RX_EMPTY = 1'b1;
    #1;
    check("t6_rv_ignored", BYTE_PHASE, 0);
    auto_src = 1'b1;
    push_byte(8'h5a); push_byte(8'h6b); push_byte(8'h7c); push_byte(8'h8d);
    wait_stall("t6_after", 30);
    check("t6_after_head", FIFO_DATA, 32'h8d7c6b5a);
    drain("t6_drain", 20);
    check("t6_words", words_popped, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_rx_8_to_32.md
Name: tcp_rx_8_to_32

Overview:
Receive-side counterpart of the 32-to-8 Tx data FIFO. It drains the TCP Rx byte stream through the USR_RX_EMPTY/RE/RV/RD handshake and packs each group of 4 bytes into one 32-bit word. Words are buffered in an internal first-word-fall-through (FWFT) FIFO, giving the USR_CLK domain a 32-bit downstream interface in the same style as the FE FIFO ports. Partial words are discarded when the TCP connection drops, and each discard is counted.

Parameters:
DEPTH, 16, word FIFO depth in 32-bit words; power of 2, minimum 4.
CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
CLK  in  1  single clock for the whole block (USR_CLK domain, 125 MHz).
RSTn  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
USR_ACTIVE  in  1  TCP connection established.
USR_RX_EMPTY  in  1  TCP Rx FIFO empty flag.
USR_RX_RE  out  1  read enable to the TCP Rx FIFO.
USR_RX_RV  in  1  Rx data valid; arrives exactly 1 cycle after an accepted RE.
USR_RX_RD  in  8  Rx data byte; valid while RV=1.
FIFO_READ  in  1  pop request for the word FIFO.
FIFO_EMPTY  out  1  word FIFO empty.
FIFO_DATA  out  32  head word of the word FIFO; valid while FIFO_EMPTY=0.
BYTE_PHASE  out  2  number of bytes held in the current partial word (0..3).
DROP_COUNT  out  CNT_WIDTH  number of partial words discarded; saturating.

Behaviour:
- Reset (RSTn=0 at a clock edge): USR_RX_RE=0, FIFO_EMPTY=1, FIFO_DATA=0, BYTE_PHASE=0, DROP_COUNT=0.
  - Word FIFO pointers and count are cleared.
  - Any in-flight byte (RV in the cycle after reset) is ignored.
  - Reset has priority over every other event.
- Read issue: USR_RX_RE = USR_ACTIVE & ~USR_RX_EMPTY & (word_count < DEPTH-1). The output is combinational.
  - Margin: at most 1 byte is in flight, so at most 1 word can complete after RE stops. The FIFO therefore never overflows and no byte is ever lost.
- Byte capture: on RV=1 the byte goes into pack register lane BYTE_PHASE. Lane 0 is bits [7:0], lane 3 is bits [31:24] (first byte received is least significant).
  - BYTE_PHASE then increments mod 4.
  - RV is accepted regardless of RE (the producer is trusted).
- Word completion: when RV=1 and BYTE_PHASE=3, {RD, pack[23:0]} is written to the word FIFO in the same cycle.
  - BYTE_PHASE wraps to 0.
  - Write-to-FIFO_EMPTY deassertion latency: 1 cycle.
- Word FIFO: synchronous and FWFT.
  - FIFO_READ while FIFO_EMPTY=1 is ignored.
  - Simultaneous write and read leaves word_count unchanged, including at count=DEPTH-1 and count=1.
  - When a read and a write occur on a 1-entry FIFO, FIFO_DATA presents the new word on the next cycle.
  - Pointers wrap modulo DEPTH.
- Connection drop: if USR_ACTIVE=0 and no byte is arriving (RV=0), BYTE_PHASE resets to 0 and the pack register clears.
  - If BYTE_PHASE was non-zero, DROP_COUNT increments once, saturating at all-ones.
  - If RV=1 in a cycle where USR_ACTIVE=0, the byte is still captured. The discard then happens on the next cycle in which RV=0.
- Buffered complete words survive a connection drop and remain readable.
- State machine (pack control): IDLE (phase 0) -> FILL (phases 1..3) -> IDLE on the 4th byte, or DROP when USR_ACTIVE=0 with RV=0.
  - DROP lasts exactly one cycle, bumps the counter, then returns to IDLE.

Decomposition:
- Shared package rx_pkg: BYTES_PER_WORD=4, PHASE_W=2, and the lane order constant LSB_FIRST.
- One sub-module, rx_word_fifo: a generic synchronous FWFT FIFO (DEPTH, WIDTH=32) with a count output. Packing logic stays in the top level of the block.

Test Plan:
1. Bytes 11,22,33,44 (hex), RV 1 cycle after each RE -> one word, FIFO_DATA=0x44332211; FIFO_EMPTY falls 1 cycle after the 4th RV.
2. 80 bytes streamed with FIFO_READ held 0, DEPTH=16 -> RE drops when word_count=15, 15 words stored, the 16th word is never written, no byte lost. After 15 pops, streaming resumes and the remaining 5 words appear in order.
3. 6 bytes, then USR_ACTIVE=0 -> 1 word readable, BYTE_PHASE returns 0, DROP_COUNT=1. Reconnect and send 4 bytes -> word aligned to the new first byte.
4. Force 300 drops with CNT_WIDTH=8 -> DROP_COUNT saturates at 255.
5. Continuous FIFO_READ with back-to-back input at count=1 and count=DEPTH-1 -> count stable, words exit in order, no duplication.
6. RSTn=0 asserted mid-word (BYTE_PHASE=2) with 3 words buffered -> the next cycle shows FIFO_EMPTY=1, BYTE_PHASE=0, RE=0, DROP_COUNT=0; the RV arriving 1 cycle after reset is ignored.
